// File: rtl/win_byte_fifo.sv
// Byte-granular circular FIFO: accepts IN_BYTES words and presents a WIN_BYTES sliding window.
// Optional feature macro: WIN_ROW_PAD_EN (a clear at stride 1 seeds one zero pad byte).
module win_byte_fifo #(
  parameter int IN_BYTES    = 8,
  parameter int WIN_BYTES   = 3,
  parameter int DEPTH_BYTES = 16,
  parameter int MAX_STRIDE  = 2,
  parameter int CNT_W       = 5,
  parameter int STR_W       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   row_done,
  input  logic [STR_W-1:0]       stride,
  input  logic [8*IN_BYTES-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [8*WIN_BYTES-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       count,
  output logic                   stride_err
);
  localparam int PTR_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  logic [7:0]       mem_q [DEPTH_BYTES];
  logic [7:0]       mem_d [DEPTH_BYTES];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stride_err_q, stride_err_d;
  logic             clr, push, pop, stride_bad;
  logic [STR_W-1:0] s_eff;

  // Pointer advance modulo DEPTH_BYTES; k is always below DEPTH_BYTES so one fold suffices.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned k);
    int unsigned t;
    t = 32'(p) + k;
    if (t >= 32'(DEPTH_BYTES)) t = t - 32'(DEPTH_BYTES);
    return t[PTR_W-1:0];
  endfunction

  assign clr        = start | row_done;
  assign stride_bad = (stride == '0) || (32'(stride) > 32'(MAX_STRIDE));
  assign s_eff      = stride_bad ? STR_W'(1) : stride;
  assign in_ready   = ~clr & ((32'(count_q) + 32'(IN_BYTES)) <= 32'(DEPTH_BYTES));
  assign out_valid  = ~clr & (32'(count_q) >= 32'(WIN_BYTES));
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign count      = count_q;
  assign stride_err = stride_err_q;

  always_comb begin
    out_data = '0;
    for (int k = 0; k < WIN_BYTES; k++) begin
      out_data[8*k +: 8] = mem_q[ptr_add(rd_ptr_q, k)];
    end
  end

  always_comb begin
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    stride_err_d = start ? 1'b0 : (stride_err_q | stride_bad);
    if (clr) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem_d[i] = '0;
      end
      rd_ptr_d = '0;
`ifdef WIN_ROW_PAD_EN
      // Stride-1 rows get a leading zero byte so the first window is left-padded.
      wr_ptr_d = (s_eff == STR_W'(1)) ? PTR_W'(1) : '0;
      count_d  = (s_eff == STR_W'(1)) ? CNT_W'(1) : '0;
`else
      wr_ptr_d = '0;
      count_d  = '0;
`endif
    end else begin
      if (push) begin
        for (int k = 0; k < IN_BYTES; k++) begin
          mem_d[ptr_add(wr_ptr_q, k)] = in_data[8*k +: 8];
        end
        wr_ptr_d = ptr_add(wr_ptr_q, IN_BYTES);
      end
      if (pop) begin
        rd_ptr_d = ptr_add(rd_ptr_q, 32'(s_eff));
      end
      count_d = count_q + (push ? CNT_W'(IN_BYTES) : '0) - (pop ? CNT_W'(s_eff) : '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      stride_err_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      stride_err_q <= stride_err_d;
    end
  end

endmodule
